// File: rtl/fir_pkg.sv
// Shared sample definitions for the hsFIRcheap datapath and its neighbours.
// Latency: none (types, constants and elaboration-time helpers only).
// Backpressure: not applicable.
package fir_pkg;

  localparam int DW_SAMPLE = 8;

  typedef logic [DW_SAMPLE-1:0] sample_t;

  // True when v is a positive power of two; used for elaboration-time checks.
  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ff.sv
// Flop-based synchronous FIFO with wrap-bit pointers and a show-ahead read port.
// Latency: a word pushed at edge k is presented on rd_data after edge k (1 cycle).
// Backpressure: push is refused when full unless a pop frees a slot on the same edge.
module sync_fifo_ff #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Clear overrides any transfer; a pop on full frees the slot the push reuses.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  // Pointer advance; clear rewinds both pointers to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage write; reset zeroes every entry so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Decimates the hsFIRcheap sample stream by DECIM at PHASE and buffers kept samples.
// Latency: a kept sample appears on o_data/o_valid one cycle after its input edge.
// Backpressure: consumer stalls via i_ready; kept samples arriving while full are dropped and flagged sticky.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int DW    = DW_SAMPLE,
  parameter int DECIM = 4,
  parameter int PHASE = 0,
  parameter int DEPTH = 8,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_level,
  output logic          o_overflow
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
  localparam logic [CW-1:0] CNT_KEEP = CW'(PHASE);

  generate
    if (DECIM < 1) begin : g_chk_decim
      $error("fir_decim_fifo: DECIM must be >= 1");
    end
    if ((PHASE < 0) || (PHASE >= DECIM)) begin : g_chk_phase
      $error("fir_decim_fifo: PHASE must lie in 0..DECIM-1");
    end
    if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_chk_depth
      $error("fir_decim_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic          keep;
  logic          pop;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;

  assign keep = i_valid && (cnt == CNT_KEEP);
  // i_ready only matters when there is something to hand over.
  assign pop  = o_valid && i_ready;
  assign push = keep && (!fifo_full || pop);

  // Phase counter advances once per input sample and wraps at DECIM-1.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_valid) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Sticky flag: a kept sample found the FIFO full with no slot being freed.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      o_overflow <= 1'b0;
    end else if (keep && fifo_full && !pop) begin
      o_overflow <= 1'b1;
    end
  end

  sync_fifo_ff #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_reset_n),
    .clear   (i_clear),
    .push    (push),
    .wr_data (i_data),
    .pop     (pop),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign o_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Self-checking bench: queue-based reference model plus per-cycle scoreboard monitor.
// Latency: inputs change 2 time units after each rising edge; outputs sampled 3 units after.
// Backpressure: i_ready is driven from directed patterns and a per-cycle toggle.
module tb_fir_decim_fifo;
  import fir_pkg::*;

  localparam int DECIM = 4;
  localparam int PHASE = 1;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           clr   = 1'b0;
  logic           vld   = 1'b0;
  logic           rdy   = 1'b0;
  sample_t        din   = '0;
  logic           o_valid;
  sample_t        o_data;
  logic [LW-1:0]  o_level;
  logic           o_overflow;

  int      n_cmp = 0;
  int      n_bad = 0;
  sample_t exp_q[$];
  int      m_cnt = 0;
  bit      m_ovf = 1'b0;
  sample_t recv[$];
  bit      hold_p = 1'b0;
  sample_t hold_d = '0;

  always #5 clk = ~clk;

  fir_decim_fifo #(
    .DW    (8),
    .DECIM (DECIM),
    .PHASE (PHASE),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_clear    (clr),
    .i_valid    (vld),
    .i_data     (din),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_data     (o_data),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: every DECIM-th sample at PHASE enters a bounded queue.
  always @(posedge clk) begin : model
    bit keep;
    bit take;
    if (rst_n) begin
      if (clr) begin
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
      end else begin
        keep = vld && (m_cnt == PHASE);
        take = (exp_q.size() != 0) && rdy;
        if (vld) m_cnt = (m_cnt + 1) % DECIM;
        if (take) void'(exp_q.pop_front());
        if (keep) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(din);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  end

  // Monitor: compare outputs with the model, check hold, log accepted samples.
  always @(posedge clk) begin
    #3;
    check("valid", o_valid, exp_q.size() != 0);
    check("level", o_level, exp_q.size());
    check("overflow", o_overflow, m_ovf);
    if (exp_q.size() != 0) check("data", o_data, exp_q[0]);
    if (hold_p && o_valid) check("hold", o_data, hold_d);
    hold_p = o_valid && !rdy && !clr && rst_n;
    hold_d = o_data;
    if (o_valid && rdy && !clr && rst_n) recv.push_back(o_data);
  end

  task automatic cyc(input logic v, input sample_t d, input logic r, input logic c);
    vld = v;
    din = d;
    rdy = r;
    clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic check_recv(input string nm, input sample_t want[$]);
    check({nm, "_count"}, recv.size(), want.size());
    foreach (want[i]) begin
      if (i < recv.size()) check(nm, recv[i], want[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t want[$];
    sample_t d;
    logic    v;
    int      vc;

    // Reset with live-looking inputs
    vld = 1'b1;
    din = 8'hFF;
    rdy = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_level", o_level, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_data", o_data, 0);
    rst_n = 1'b1;
    vld = 1'b0;
    rdy = 1'b0;

    // Decimation by 4 at phase 1
    recv.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, sample_t'(i), 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    want = '{8'd1, 8'd5, 8'd9, 8'd13};
    check_recv("decim", want);

    // Full FIFO with a simultaneous pop and kept sample
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 32; j++) begin
      d = ((j % 4) == 1) ? sample_t'(8'h20 + j / 4) : sample_t'($urandom);
      cyc(1'b1, d, 1'b0, 1'b0);
    end
    check("full_level", o_level, 8);
    check("full_overflow", o_overflow, 0);
    cyc(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    recv.delete();
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullpop_level", o_level, 8);
    check("fullpop_overflow", o_overflow, 0);
    repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
    want.delete();
    for (int k = 0; k < 8; k++) want.push_back(sample_t'(8'h20 + k));
    want.push_back(8'hAA);
    check_recv("fullpop", want);

    // Overflow: ten kept samples into eight entries
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int j = 0; j < 40; j++) begin
      d = ((j % 4) == 1) ? sample_t'(8'h10 + j / 4) : sample_t'($urandom);
      cyc(1'b1, d, 1'b0, 1'b0);
    end
    check("ovf_level", o_level, 8);
    check("ovf_flag", o_overflow, 1);
    recv.delete();
    repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
    want.delete();
    for (int k = 0; k < 8; k++) want.push_back(sample_t'(8'h10 + k));
    check_recv("ovf_drain", want);
    check("ovf_sticky", o_overflow, 1);
    check("ovf_empty", o_valid, 0);

    // Random stream with i_ready toggling every cycle
    cyc(1'b0, '0, 1'b0, 1'b1);
    recv.delete();
    want.delete();
    vc = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = sample_t'($urandom);
      if (v) begin
        if ((vc % DECIM) == PHASE) want.push_back(d);
        vc++;
      end
      cyc(v, d, (i % 2) == 1, 1'b0);
    end
    repeat (12) cyc(1'b0, '0, 1'b1, 1'b0);
    check_recv("bp_stream", want);
    check("bp_overflow", o_overflow, 0);

    // Synchronous clear mid-stream
    cyc(1'b0, '0, 1'b0, 1'b1);
    repeat (36) cyc(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    check("preclr_level", o_level, 5);
    check("preclr_overflow", o_overflow, 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_level", o_level, 0);
    check("clr_overflow", o_overflow, 0);
    check("clr_valid", o_valid, 0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    check("clr_phase0_level", o_level, 0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    check("clr_phase1_level", o_level, 1);
    check("clr_phase1_data", o_data, 8'h66);

    // Asynchronous reset pulse mid-stream
    repeat (36) cyc(1'b1, sample_t'($urandom), 1'b0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("prerst_level", o_level, 5);
    check("prerst_overflow", o_overflow, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", o_level, 0);
    check("arst_overflow", o_overflow, 0);
    check("arst_valid", o_valid, 0);
    check("arst_data", o_data, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    check("arst_phase0_level", o_level, 0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    check("arst_phase1_level", o_level, 1);
    check("arst_phase1_data", o_data, 8'h66);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
